lpm_pm_responder: RTL and testbench

//  Program-memory read responder for the LPM instruction. It reacts to the LPM_enable

---
 rtl/lpm_pm_responder_if.sv | 26 ++
 rtl/lpm_pm_responder.sv | 171 +++++++++++++++++
 tb/tb_lpm_pm_responder.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lpm_pm_responder_if.sv
// Program-memory read-port bundle used by the LPM responder.
//   master : requester side (drives pm_rd_en / pm_addr, receives pm_rdata / pm_rvalid)
//   slave  : program-memory side
// Parameter ADDR_W: program-memory word-address width.
interface lpm_pm_responder_if #(
  parameter int unsigned ADDR_W = 14
) ();
  logic              pm_rd_en;
  logic [ADDR_W-1:0] pm_addr;
  logic [15:0]       pm_rdata;
  logic              pm_rvalid;

  modport master (
    output pm_rd_en,
    output pm_addr,
    input  pm_rdata,
    input  pm_rvalid
  );

  modport slave (
    input  pm_rd_en,
    input  pm_addr,
    output pm_rdata,
    output pm_rvalid
  );
endinterface

// File: rtl/lpm_pm_responder.sv
// LPM program-memory read responder.
// A rising LPM_enable launches one read of the flash word addressed by Z; the low or high
// byte (selected by Z[0]) is returned on lpm_data with a one-cycle lpm_wr_en strobe.
// Ports:
//   clk, reset_n    clock and synchronous active-low reset
//   LPM_enable      request strobe from the control unit (2 cycles high per LPM)
//   z_ptr           Z register (byte address)
//   pm              program-memory read port (master modport)
//   lpm_data        selected byte, held until the next valid read
//   lpm_wr_en       one-cycle write strobe towards Rd
//   busy            transaction in progress
//   err_timeout     sticky read-timeout flag, cleared only by reset
// Optional feature (macro LPM_POSTINC_EN): adds lpm_postinc, z_next and z_wr_en for the
// LPM Rd,Z+ form. Without the macro Z is never modified.
module lpm_pm_responder #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       LPM_enable,
  input  logic [15:0]                z_ptr,
  lpm_pm_responder_if.master         pm,
  output logic [7:0]                 lpm_data,
  output logic                       lpm_wr_en,
  output logic                       busy,
  output logic                       err_timeout
`ifdef LPM_POSTINC_EN
  ,
  input  logic                       lpm_postinc,
  output logic [15:0]                z_next,
  output logic                       z_wr_en
`endif
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic              en_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic              zlsb_q, zlsb_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        data_q, data_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              start;
  logic [7:0]        cnt_inc;
  logic              unused_z_hi;

`ifdef LPM_POSTINC_EN
  logic [15:0]       z_q, z_d;
  logic              postinc_q, postinc_d;
  logic [15:0]       z_next_q, z_next_d;
  logic              z_wr_q, z_wr_d;
`endif

  // Z bits above the word address do not take part; the address wraps modulo 2^ADDR_W.
  assign unused_z_hi = ^(z_ptr >> (ADDR_W + 1));

  // One request per rising edge of the strobe, however long it stays high.
  assign start   = LPM_enable & ~en_q;
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_en_d = 1'b0;
    zlsb_d  = zlsb_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    busy_d  = busy_q;
    err_d   = err_q;
`ifdef LPM_POSTINC_EN
    z_d       = z_q;
    postinc_d = postinc_q;
    z_next_d  = z_next_q;
    z_wr_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWait;
          addr_d  = z_ptr[ADDR_W:1];
          zlsb_d  = z_ptr[0];
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = 8'd0;
`ifdef LPM_POSTINC_EN
          z_d       = z_ptr;
          postinc_d = lpm_postinc;
`endif
        end
      end
      StWait: begin
        cnt_d = cnt_inc;
        // rvalid takes priority over a timeout expiring in the same cycle.
        if (pm.pm_rvalid) begin
          data_d  = zlsb_q ? pm.pm_rdata[15:8] : pm.pm_rdata[7:0];
          wr_d    = 1'b1;
          state_d = StDone;
`ifdef LPM_POSTINC_EN
          z_next_d = z_q + 16'd1;
          z_wr_d   = postinc_q;
`endif
        end else if (cnt_inc == 8'(TIMEOUT)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      en_q    <= 1'b0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      zlsb_q  <= 1'b0;
      cnt_q   <= 8'd0;
      data_q  <= 8'h00;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LPM_POSTINC_EN
      z_q       <= 16'h0000;
      postinc_q <= 1'b0;
      z_next_q  <= 16'h0000;
      z_wr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      en_q    <= LPM_enable;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      zlsb_q  <= zlsb_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
`ifdef LPM_POSTINC_EN
      z_q       <= z_d;
      postinc_q <= postinc_d;
      z_next_q  <= z_next_d;
      z_wr_q    <= z_wr_d;
`endif
    end
  end

  assign pm.pm_rd_en = rd_en_q;
  assign pm.pm_addr  = addr_q;
  assign lpm_data    = data_q;
  assign lpm_wr_en   = wr_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;
`ifdef LPM_POSTINC_EN
  assign z_next  = z_next_q;
  assign z_wr_en = z_wr_q;
`endif

endmodule

// File: tb/tb_lpm_pm_responder.sv
// Self-checking bench for lpm_pm_responder: scoreboard of expected addresses and bytes,
// with per-scenario tasks driving LPM requests and a simple program-memory responder.
module tb_lpm_pm_responder;

  logic        clk;
  logic        reset_n;
  logic        LPM_enable;
  logic [15:0] z_ptr;
  logic [7:0]  lpm_data;
  logic        lpm_wr_en;
  logic        busy;
  logic        err_timeout;
`ifdef LPM_POSTINC_EN
  logic        lpm_postinc;
  logic [15:0] z_next;
  logic        z_wr_en;
`endif

  lpm_pm_responder_if #(.ADDR_W(14)) pm_if ();

  lpm_pm_responder #(
    .ADDR_W (14),
    .TIMEOUT(15)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .LPM_enable (LPM_enable),
    .z_ptr      (z_ptr),
    .pm         (pm_if),
    .lpm_data   (lpm_data),
    .lpm_wr_en  (lpm_wr_en),
    .busy       (busy),
    .err_timeout(err_timeout)
`ifdef LPM_POSTINC_EN
    ,
    .lpm_postinc(lpm_postinc),
    .z_next     (z_next),
    .z_wr_en    (z_wr_en)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expectations pushed with stimulus, observations pushed by tick().
  logic [13:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  logic [13:0] got_addr[$];
  logic [7:0]  got_data[$];
  int cyc = 0;
  int n_rd = 0;
  int n_wr = 0;
  int last_wr_cyc = -1;
`ifdef LPM_POSTINC_EN
  int n_zwr = 0;
  int last_zwr_cyc = -1;
`endif

  // Snapshot taken right after a mid-transaction reset edge.
  logic [13:0] snap_addr;
  logic [7:0]  snap_data;
  logic        snap_rd, snap_wr, snap_busy, snap_err;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pm_if.pm_rd_en) begin
      n_rd++;
      got_addr.push_back(pm_if.pm_addr);
    end
    if (lpm_wr_en) begin
      n_wr++;
      last_wr_cyc = cyc;
      got_data.push_back(lpm_data);
    end
`ifdef LPM_POSTINC_EN
    if (z_wr_en) begin
      n_zwr++;
      last_zwr_cyc = cyc;
    end
`endif
  endtask

  function automatic logic [13:0] pop_got_addr();
    if (got_addr.size() == 0) return 'x;
    return got_addr.pop_front();
  endfunction

  function automatic logic [7:0] pop_got_data();
    if (got_data.size() == 0) return 'x;
    return got_data.pop_front();
  endfunction

  // Drives one LPM request for ncyc cycles. delay<0: memory never answers.
  // extra_iter>=0: raise a second 2-cycle strobe there. reset_iter>=0: pulse reset there.
  task automatic run_lpm(input logic [15:0] z, input logic [15:0] rdata, input int delay,
                         input bit postinc, input int extra_iter, input int reset_iter,
                         input int ncyc, output int rd_iter, output int wr_iter,
                         output int err_iter);
    int  rv_iter;
    int  wr_before;
    bit  err_prev;
    rd_iter  = -1;
    wr_iter  = -1;
    err_iter = -1;
    rv_iter  = -1;
    err_prev = err_timeout;
    z_ptr = z;
    pm_if.pm_rdata = rdata;
`ifdef LPM_POSTINC_EN
    lpm_postinc = postinc;
`else
    if (postinc) z_ptr = z;
`endif
    for (int c = 0; c < ncyc; c++) begin
      LPM_enable = (c < 2) || (extra_iter >= 0 && (c == extra_iter || c == extra_iter + 1));
      pm_if.pm_rvalid = (c == rv_iter);
      reset_n = (c != reset_iter);
      wr_before = n_wr;
      tick();
      if (c == reset_iter) begin
        snap_addr = pm_if.pm_addr;
        snap_data = lpm_data;
        snap_rd   = pm_if.pm_rd_en;
        snap_wr   = lpm_wr_en;
        snap_busy = busy;
        snap_err  = err_timeout;
      end
      if (pm_if.pm_rd_en && rd_iter < 0) begin
        rd_iter = c;
        if (delay >= 0) rv_iter = c + 1 + delay;
      end
      if (n_wr != wr_before && wr_iter < 0) wr_iter = c;
      if (err_timeout && !err_prev && err_iter < 0) err_iter = c;
      err_prev = err_timeout;
    end
    LPM_enable = 1'b0;
    pm_if.pm_rvalid = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    checks++; if (pm_if.pm_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", pm_if.pm_rd_en); end
    checks++; if (pm_if.pm_addr !== 14'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0000", pm_if.pm_addr); end
    checks++; if (lpm_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", lpm_data); end
    checks++; if (lpm_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", lpm_wr_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_timeout); end
`ifdef LPM_POSTINC_EN
    checks++; if (z_next !== 16'h0 || z_wr_en !== 1'b0) begin errors++; $display("FAIL reset_znext: got %h/%b expected 0000/0", z_next, z_wr_en); end
`endif
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic test_low_byte();
    int rd0, wr0, rdi, wri, eri;
    logic [13:0] a;
    logic [7:0]  d;
    rd0 = n_rd; wr0 = n_wr;
    exp_addr.push_back(14'h0080);
    exp_data.push_back(8'hEF);
    run_lpm(16'h0100, 16'hBEEF, 1, 1'b0, -1, -1, 8, rdi, wri, eri);
    a = pop_got_addr(); d = pop_got_data();
    checks++; if (a !== exp_addr[0]) begin errors++; $display("FAIL low_addr: got %h expected %h", a, exp_addr[0]); end
    checks++; if (d !== exp_data[0]) begin errors++; $display("FAIL low_data: got %h expected %h", d, exp_data[0]); end
    void'(exp_addr.pop_front()); void'(exp_data.pop_front());
    checks++; if (n_rd - rd0 != 1) begin errors++; $display("FAIL low_rd_count: got %0d expected 1", n_rd - rd0); end
    checks++; if (n_wr - wr0 != 1) begin errors++; $display("FAIL low_wr_count: got %0d expected 1", n_wr - wr0); end
    // Start sampled at edge 0, write strobe visible in cycle 3.
    checks++; if (wri != 2) begin errors++; $display("FAIL low_latency: got iter %0d expected 2", wri); end
    checks++; if (busy !== 1'b0 || lpm_data !== 8'hEF) begin errors++; $display("FAIL low_hold: got busy %b data %h expected 0/ef", busy, lpm_data); end
  endtask

  task automatic test_high_byte_wrap();
    int rdi, wri, eri;
    logic [13:0] a;
    logic [7:0]  d;
    exp_addr.push_back(14'h0080);
    exp_data.push_back(8'hBE);
    run_lpm(16'h0101, 16'hBEEF, 1, 1'b0, -1, -1, 8, rdi, wri, eri);
    a = pop_got_addr(); d = pop_got_data();
    checks++; if (a !== exp_addr[0]) begin errors++; $display("FAIL high_addr: got %h expected %h", a, exp_addr[0]); end
    checks++; if (d !== exp_data[0]) begin errors++; $display("FAIL high_data: got %h expected %h", d, exp_data[0]); end
    void'(exp_addr.pop_front()); void'(exp_data.pop_front());
    exp_addr.push_back(14'h3FFF);
    exp_data.push_back(8'h12);
    run_lpm(16'hFFFF, 16'h1234, 3, 1'b0, -1, -1, 10, rdi, wri, eri);
    a = pop_got_addr(); d = pop_got_data();
    checks++; if (a !== exp_addr[0]) begin errors++; $display("FAIL wrap_addr: got %h expected %h", a, exp_addr[0]); end
    checks++; if (d !== exp_data[0]) begin errors++; $display("FAIL wrap_data: got %h expected %h", d, exp_data[0]); end
    void'(exp_addr.pop_front()); void'(exp_data.pop_front());
    checks++; if (wri != rdi + 4) begin errors++; $display("FAIL wrap_latency: got iter %0d expected %0d", wri, rdi + 4); end
    checks++; if (pm_if.pm_addr !== 14'h3FFF) begin errors++; $display("FAIL addr_hold: got %h expected 3fff", pm_if.pm_addr); end
  endtask

  task automatic test_timeout();
    int wr0, rdi, wri, eri;
    logic [7:0] d;
    wr0 = n_wr;
    exp_addr.push_back(14'h0010);
    run_lpm(16'h0020, 16'hAAAA, -1, 1'b0, -1, -1, 30, rdi, wri, eri);
    checks++; if (pop_got_addr() !== exp_addr.pop_front()) begin errors++; $display("FAIL to_addr: address differs from expected 0010"); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", err_timeout); end
    checks++; if (eri - rdi != 15) begin errors++; $display("FAIL to_cycles: got %0d expected 15", eri - rdi); end
    checks++; if (n_wr != wr0) begin errors++; $display("FAIL to_no_write: got %0d writes expected 0", n_wr - wr0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b expected 0", busy); end
    exp_addr.push_back(14'h0011);
    exp_data.push_back(8'h55);
    run_lpm(16'h0023, 16'h55AA, 2, 1'b0, -1, -1, 10, rdi, wri, eri);
    void'(pop_got_addr()); void'(exp_addr.pop_front());
    d = pop_got_data();
    checks++; if (d !== exp_data[0]) begin errors++; $display("FAIL to_next_data: got %h expected %h", d, exp_data[0]); end
    void'(exp_data.pop_front());
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", err_timeout); end
  endtask

  task automatic test_back_to_back();
    int rd0, wr0, rdi, wri, eri;
    logic [7:0] d;
    rd0 = n_rd; wr0 = n_wr;
    exp_data.push_back(8'h3C);
    run_lpm(16'h0200, 16'hC33C, 6, 1'b0, 4, -1, 14, rdi, wri, eri);
    checks++; if (n_rd - rd0 != 1) begin errors++; $display("FAIL b2b_rd_count: got %0d expected 1", n_rd - rd0); end
    checks++; if (n_wr - wr0 != 1) begin errors++; $display("FAIL b2b_wr_count: got %0d expected 1", n_wr - wr0); end
    d = pop_got_data();
    checks++; if (d !== exp_data[0]) begin errors++; $display("FAIL b2b_data: got %h expected %h", d, exp_data[0]); end
    void'(exp_data.pop_front());
    got_addr.delete();
  endtask

  task automatic test_reset_abort();
    int wr0, rdi, wri, eri;
    logic [7:0] d;
    wr0 = n_wr;
    run_lpm(16'h0301, 16'h9966, 3, 1'b0, -1, 2, 10, rdi, wri, eri);
    checks++; if ({snap_rd, snap_wr, snap_busy, snap_err} !== 4'b0000) begin errors++; $display("FAIL abort_flags: got %b expected 0000", {snap_rd, snap_wr, snap_busy, snap_err}); end
    checks++; if (snap_addr !== 14'h0 || snap_data !== 8'h00) begin errors++; $display("FAIL abort_regs: got %h/%h expected 0000/00", snap_addr, snap_data); end
    checks++; if (n_wr != wr0 || lpm_data !== 8'h00) begin errors++; $display("FAIL abort_late_rvalid: got %0d writes data %h expected 0/00", n_wr - wr0, lpm_data); end
    got_addr.delete();
    exp_data.push_back(8'h77);
    run_lpm(16'h0400, 16'h8877, 1, 1'b0, -1, -1, 8, rdi, wri, eri);
    d = pop_got_data();
    checks++; if (d !== exp_data[0]) begin errors++; $display("FAIL abort_next_data: got %h expected %h", d, exp_data[0]); end
    void'(exp_data.pop_front());
    got_addr.delete();
  endtask

`ifdef LPM_POSTINC_EN
  task automatic test_postinc();
    int z0, rdi, wri, eri;
    z0 = n_zwr;
    run_lpm(16'hFFFF, 16'h4321, 1, 1'b1, -1, -1, 8, rdi, wri, eri);
    checks++; if (z_next !== 16'h0000) begin errors++; $display("FAIL pi_znext: got %h expected 0000", z_next); end
    checks++; if (n_zwr - z0 != 1) begin errors++; $display("FAIL pi_zwr_count: got %0d expected 1", n_zwr - z0); end
    checks++; if (last_zwr_cyc != last_wr_cyc) begin errors++; $display("FAIL pi_align: got cycle %0d expected %0d", last_zwr_cyc, last_wr_cyc); end
    z0 = n_zwr;
    run_lpm(16'h0010, 16'h4321, 1, 1'b0, -1, -1, 8, rdi, wri, eri);
    checks++; if (n_zwr != z0) begin errors++; $display("FAIL pi_off: got %0d pulses expected 0", n_zwr - z0); end
    got_addr.delete();
    got_data.delete();
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    LPM_enable = 1'b0;
    z_ptr = 16'h0000;
    pm_if.pm_rdata = 16'h0000;
    pm_if.pm_rvalid = 1'b0;
`ifdef LPM_POSTINC_EN
    lpm_postinc = 1'b0;
`endif
    test_reset();
    test_low_byte();
    test_high_byte_wrap();
    test_timeout();
    test_back_to_back();
    test_reset_abort();
`ifdef LPM_POSTINC_EN
    test_postinc();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
